// File: rtl/time_keeper.sv
// time_keeper: 12-hour wall clock (hour 1..12, minute, second, PM flag) driven by a
// clk prescaler. Every hour/minute/PM change is pushed to the LED/seven-segment
// controller as a single Avalon-MM master write of {3'b0, pm, hour, 2'b0, minute, 16'h0}.
//
// Ports
//   clk              clock
//   reset            asynchronous, active-high
//   run_en           1 = time advances, 0 = prescaler and counters frozen
//   set_en           one-cycle load strobe for set_hour/set_minute/set_pm
//   set_hour/minute/pm  load values (hour 1..12, minute 0..59)
//   set_err          one-cycle pulse when a load carried an illegal value
//   cur_hour/minute/second/pm  live registered time
//   avm_write/writedata/byteenable  Avalon-MM master write request
//   avm_waitrequest  slave stall
module time_keeper #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_en,
    input  logic        set_en,
    input  logic [3:0]  set_hour,
    input  logic [5:0]  set_minute,
    input  logic        set_pm,
    output logic        set_err,
    output logic [3:0]  cur_hour,
    output logic [5:0]  cur_minute,
    output logic [5:0]  cur_second,
    output logic        cur_pm,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest
);

    localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    typedef enum logic {
        StIdle,
        StWrite
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [3:0]    hour_q, hour_d;
    logic [5:0]    minute_q, minute_d;
    logic [5:0]    second_q, second_d;
    logic          pm_q, pm_d;
    logic          dirty_q, dirty_d;
    logic          set_err_q, set_err_d;
    logic [31:0]   wdata_q, wdata_d;

    logic tick;
    logic set_legal;
    logic change;
    logic snap;

    assign tick      = run_en && (prescaler_q == PRE_MAX);
    assign set_legal = (set_hour != 4'd0) && (set_hour <= 4'd12) && (set_minute <= 6'd59);

    // Time counters, prescaler and load port.
    always_comb begin
        prescaler_d = prescaler_q;
        hour_d      = hour_q;
        minute_d    = minute_q;
        second_d    = second_q;
        pm_d        = pm_q;
        set_err_d   = 1'b0;
        change      = 1'b0;

        if (set_en) begin
            // A load wins over a tick; an illegal load freezes everything this cycle.
            if (set_legal) begin
                hour_d      = set_hour;
                minute_d    = set_minute;
                pm_d        = set_pm;
                second_d    = 6'd0;
                prescaler_d = '0;
                change      = 1'b1;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (run_en) begin
            if (tick) begin
                prescaler_d = '0;
                if (second_q == 6'd59) begin
                    second_d = 6'd0;
                    change   = 1'b1;
                    if (minute_q == 6'd59) begin
                        minute_d = 6'd0;
                        if (hour_q == 4'd12) begin
                            hour_d = 4'd1;
                        end else begin
                            hour_d = hour_q + 4'd1;
                        end
                        if (hour_q == 4'd11) begin
                            pm_d = ~pm_q;
                        end
                    end else begin
                        minute_d = minute_q + 6'd1;
                    end
                end else begin
                    second_d = second_q + 6'd1;
                end
            end else begin
                prescaler_d = prescaler_q + 1'b1;
            end
        end
    end

    // Write FSM: snapshot the time when dirty, hold the request until accepted.
    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        snap    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dirty_q) begin
                    snap    = 1'b1;
                    wdata_d = {3'b000, pm_q, hour_q, 2'b00, minute_q, 16'h0000};
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (!avm_waitrequest) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A change landing on the snapshot edge keeps dirty set so the newer time follows.
        dirty_d = change | (dirty_q & ~snap);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            prescaler_q <= '0;
            hour_q      <= 4'd12;
            minute_q    <= 6'd0;
            second_q    <= 6'd0;
            pm_q        <= 1'b0;
            dirty_q     <= 1'b1;
            set_err_q   <= 1'b0;
            wdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            hour_q      <= hour_d;
            minute_q    <= minute_d;
            second_q    <= second_d;
            pm_q        <= pm_d;
            dirty_q     <= dirty_d;
            set_err_q   <= set_err_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cur_hour       = hour_q;
    assign cur_minute     = minute_q;
    assign cur_second     = second_q;
    assign cur_pm         = pm_q;
    assign set_err        = set_err_q;
    assign avm_write      = (state_q == StWrite);
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = avm_write ? 4'b1100 : 4'b0000;

endmodule

// File: tb/tb_time_keeper.sv
// Directed testbench for time_keeper with CLK_HZ=4 (one tick every 4 enabled cycles).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_time_keeper;

    logic        clk;
    logic        reset;
    logic        run_en;
    logic        set_en;
    logic [3:0]  set_hour;
    logic [5:0]  set_minute;
    logic        set_pm;
    logic        set_err;
    logic [3:0]  cur_hour;
    logic [5:0]  cur_minute;
    logic [5:0]  cur_second;
    logic        cur_pm;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;

    int pass_cnt = 0;
    int total    = 0;

    // Completed transfers and set_err pulses, observed by monitors.
    int          wr_count  = 0;
    int          err_count = 0;
    logic [31:0] wr_data   = '0;
    logic [3:0]  wr_be     = '0;

    time_keeper #(
        .CLK_HZ(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .run_en         (run_en),
        .set_en         (set_en),
        .set_hour       (set_hour),
        .set_minute     (set_minute),
        .set_pm         (set_pm),
        .set_err        (set_err),
        .cur_hour       (cur_hour),
        .cur_minute     (cur_minute),
        .cur_second     (cur_second),
        .cur_pm         (cur_pm),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!reset && avm_write && !avm_waitrequest) begin
            wr_count <= wr_count + 1;
            wr_data  <= avm_writedata;
            wr_be    <= avm_byteenable;
        end
        if (!reset && set_err) begin
            err_count <= err_count + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_set(input logic [3:0] h, input logic [5:0] m, input logic p);
        set_hour   = h;
        set_minute = m;
        set_pm     = p;
        set_en     = 1'b1;
        step(1);
        set_en     = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        run_en = 1'b1;
        step(n);
        run_en = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        reset = 1'b1;
        step(2);
        @(negedge clk);
        total++;
        if ({cur_hour, cur_minute, cur_second, cur_pm} !== {4'd12, 6'd0, 6'd0, 1'b0}) begin
            $display("FAIL reset_time: got %0d:%0d:%0d pm=%0b, want 12:0:0 pm=0",
                     cur_hour, cur_minute, cur_second, cur_pm);
        end else pass_cnt++;
        total++;
        if ({avm_write, avm_writedata, avm_byteenable, set_err} !== 38'h0) begin
            $display("FAIL reset_bus: got wr=%0b data=%h be=%h err=%0b, want all 0",
                     avm_write, avm_writedata, avm_byteenable, set_err);
        end else pass_cnt++;
        step(1);
        reset = 1'b0;
        base  = wr_count;
        @(negedge clk);
        total++;
        if (avm_write !== 1'b0) begin
            $display("FAIL first_write_early: got wr=%0b, want 0", avm_write);
        end else pass_cnt++;
        step(1);
        @(negedge clk);
        total++;
        if ({avm_write, avm_writedata, avm_byteenable} !== {1'b1, 32'h0C00_0000, 4'hC}) begin
            $display("FAIL first_write: got wr=%0b data=%h be=%h, want 1 0c000000 c",
                     avm_write, avm_writedata, avm_byteenable);
        end else pass_cnt++;
        step(1);
        @(negedge clk);
        total++;
        if ({avm_write, avm_writedata, avm_byteenable} !== {1'b0, 32'h0C00_0000, 4'h0}) begin
            $display("FAIL write_done: got wr=%0b data=%h be=%h, want 0 0c000000 0",
                     avm_write, avm_writedata, avm_byteenable);
        end else pass_cnt++;
        step(1);
        total++;
        if (wr_count - base !== 1) begin
            $display("FAIL reset_write_count: got %0d, want 1", wr_count - base);
        end else pass_cnt++;
        // 59 seconds: seconds change, minute does not, so no further writes.
        base = wr_count;
        run_cycles(59 * 4);
        step(3);
        total++;
        if ({cur_hour, cur_minute, cur_second} !== {4'd12, 6'd0, 6'd59} || wr_count != base) begin
            $display("FAIL run_59s: got %0d:%0d:%0d writes=%0d, want 12:0:59 writes=0",
                     cur_hour, cur_minute, cur_second, wr_count - base);
        end else pass_cnt++;
    endtask

    task automatic test_pm_roll();
        int base;
        do_set(4'd11, 6'd59, 1'b0);
        step(3);
        base = wr_count;
        run_cycles(60 * 4);
        step(3);
        total++;
        if (wr_count - base !== 1 || wr_data !== 32'h1C00_0000 || wr_be !== 4'hC) begin
            $display("FAIL pm_roll_write: got n=%0d data=%h be=%h, want 1 1c000000 c",
                     wr_count - base, wr_data, wr_be);
        end else pass_cnt++;
        total++;
        if ({cur_hour, cur_minute, cur_second, cur_pm} !== {4'd12, 6'd0, 6'd0, 1'b1}) begin
            $display("FAIL pm_roll_time: got %0d:%0d:%0d pm=%0b, want 12:0:0 pm=1",
                     cur_hour, cur_minute, cur_second, cur_pm);
        end else pass_cnt++;
    endtask

    task automatic test_hour_wrap();
        int base;
        do_set(4'd12, 6'd59, 1'b1);
        step(3);
        base = wr_count;
        run_cycles(60 * 4);
        step(3);
        total++;
        if (wr_count - base !== 1 || wr_data !== 32'h1100_0000) begin
            $display("FAIL hour_wrap_write: got n=%0d data=%h, want 1 11000000",
                     wr_count - base, wr_data);
        end else pass_cnt++;
        total++;
        if ({cur_hour, cur_minute, cur_pm} !== {4'd1, 6'd0, 1'b1}) begin
            $display("FAIL hour_wrap_time: got %0d:%0d pm=%0b, want 1:0 pm=1",
                     cur_hour, cur_minute, cur_pm);
        end else pass_cnt++;
    endtask

    task automatic test_stall();
        int base;
        int bad = 0;
        avm_waitrequest = 1'b1;
        do_set(4'd3, 6'd30, 1'b0);
        step(1);
        base = wr_count;
        for (int i = 1; i <= 6; i++) begin
            if (i == 2) begin
                set_hour   = 4'd10;
                set_minute = 6'd5;
                set_pm     = 1'b0;
                set_en     = 1'b1;
            end
            if (i == 3) set_en = 1'b0;
            if (i == 6) avm_waitrequest = 1'b0;
            @(negedge clk);
            total++;
            if ({avm_write, avm_writedata, avm_byteenable} !== {1'b1, 32'h031E_0000, 4'hC}) begin
                $display("FAIL stall_hold[%0d]: got wr=%0b data=%h be=%h, want 1 031e0000 c",
                         i, avm_write, avm_writedata, avm_byteenable);
                bad++;
            end else pass_cnt++;
            step(1);
        end
        @(negedge clk);
        total++;
        if (avm_write !== 1'b0) begin
            $display("FAIL stall_gap: got wr=%0b, want 0", avm_write);
        end else pass_cnt++;
        step(4);
        total++;
        if (wr_count - base !== 2 || wr_data !== 32'h0A05_0000) begin
            $display("FAIL stall_followup: got n=%0d last=%h, want 2 0a050000",
                     wr_count - base, wr_data);
        end else pass_cnt++;
    endtask

    task automatic test_set_err();
        int base;
        int ebase;
        base  = wr_count;
        ebase = err_count;
        do_set(4'd0, 6'd10, 1'b1);
        @(negedge clk);
        total++;
        if (set_err !== 1'b1) begin
            $display("FAIL set_err_hour0: got %0b, want 1", set_err);
        end else pass_cnt++;
        do_set(4'd5, 6'd60, 1'b1);
        do_set(4'd13, 6'd0, 1'b1);
        step(1);
        @(negedge clk);
        total++;
        if (err_count - ebase !== 3 || set_err !== 1'b0) begin
            $display("FAIL set_err_pulses: got n=%0d now=%0b, want 3 0",
                     err_count - ebase, set_err);
        end else pass_cnt++;
        step(3);
        total++;
        if ({cur_hour, cur_minute, cur_pm} !== {4'd10, 6'd5, 1'b0} || wr_count != base) begin
            $display("FAIL set_err_state: got %0d:%0d pm=%0b writes=%0d, want 10:5 pm=0 0",
                     cur_hour, cur_minute, cur_pm, wr_count - base);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int base;
        avm_waitrequest = 1'b1;
        do_set(4'd7, 6'd15, 1'b1);
        step(1);
        total++;
        if (avm_write !== 1'b1) begin
            $display("FAIL mid_pre: got wr=%0b, want 1", avm_write);
        end else pass_cnt++;
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({avm_write, avm_writedata, cur_hour} !== {1'b0, 32'h0, 4'd12}) begin
            $display("FAIL mid_async: got wr=%0b data=%h hour=%0d, want 0 00000000 12",
                     avm_write, avm_writedata, cur_hour);
        end else pass_cnt++;
        step(2);
        avm_waitrequest = 1'b0;
        reset = 1'b0;
        base  = wr_count;
        step(4);
        total++;
        if (wr_count - base !== 1 || wr_data !== 32'h0C00_0000) begin
            $display("FAIL mid_rewrite: got n=%0d data=%h, want 1 0c000000",
                     wr_count - base, wr_data);
        end else pass_cnt++;
    endtask

    initial begin
        reset           = 1'b1;
        run_en          = 1'b0;
        set_en          = 1'b0;
        set_hour        = 4'd0;
        set_minute      = 6'd0;
        set_pm          = 1'b0;
        avm_waitrequest = 1'b0;
        test_reset();
        test_pm_roll();
        test_hour_wrap();
        test_stall();
        test_set_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
